// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_WIDTH_DEF     = 16;
    localparam int APB_DATA_WIDTH_DEF     = 32;
    localparam int APB_TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: one-hot grant from req_vld_i, search starts after the last accepted index.
// Pure combinational grant; pointer only moves on accept_i.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_vld_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = last_q;
        found     = 1'b0;
        cand      = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_vld_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_idx_o    = cand;
            end
        end
    end

    assign last_d = accept_i ? gnt_idx_o : last_q;

    // Reset to the top index so requester 0 is first after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: accept->psel 1 cycle, rsp_valid 3 cycles + wait states; req_ready only in IDLE.
// APB_ARB_TIMEOUT_EN adds a pready-low abort after TIMEOUT_CYCLES ACCESS cycles.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEF
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic                          psel,
    output logic                          penable,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic                          pready,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pslverr
);
    localparam int IDX_W = $clog2(NUM_REQ);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  accept;
    logic                  timeout;

    assign accept = (state_q == IDLE) && (|req_valid);

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk_i     (pclk),
        .rst_ni    (preset_n),
        .req_vld_i (req_valid),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of pready-low ACCESS cycles already elapsed.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !pready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        rsp_vld_d   = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    write_d = req_write[gnt_idx];
                    wdata_d = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    idx_d   = gnt_idx;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    rsp_vld_d[idx_q] = 1'b1;
                    rsp_rdata_d      = write_q ? '0 : prdata;
                    rsp_err_d        = pslverr;
                    state_d          = IDLE;
                end else if (timeout) begin
                    rsp_vld_d[idx_q] = 1'b1;
                    rsp_rdata_d      = '0;
                    rsp_err_d        = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            idx_q       <= '0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? gnt : '0;
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pwdata    = wdata_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
